alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//   Registered output stage directly downstream of the 32-bit bitwise/arith units (NOR, AND, OR, ADD...).
//   Captures the selected 32-bit ALU result plus its opcode into a 2-entry skid buffer with valid/ready handshake.
//   Derives zero/negative flags at capture and counts delivered results.
//   Decouples combinational ALU datapath from the consumer (register-file writeback).
// PARAMETERS
//   WIDTH      32  data width of result path
//   OPW        3   width of opcode tag carried with each result
//   CNTW       16  width of delivered-result counter
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high reset
//   in_valid    in   1      upstream result valid
//   in_ready    out  1      stage can accept this cycle
//   in_result   in   WIDTH  ALU result (e.g. NOR output)
//   in_op       in   OPW    opcode that produced in_result
//   out_valid   out  1      head entry valid
//   out_ready   in   1      consumer accepts head this cycle
//   out_result  out  WIDTH  head result
//   out_op      out  OPW    head opcode
//   out_zero    out  1      head result == 0
//   out_neg     out  1      head result[WIDTH-1]
//   out_count   out  CNTW   number of results delivered since reset
// BEHAVIOUR
//   - Storage: 2 entries {result, op, zero, neg}; occupancy cnt in {0,1,2}; head/tail pointers 1 bit each.
//   - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on same rising edge.
//   - in_ready = (cnt != 2), derived from registered state only; no combinational path from out_ready.
//   - out_valid = (cnt != 0); out_* driven from head entry, registered, no combinational path from in_*.
//   - Latency: push into empty stage at edge N -> out_valid=1, data visible after edge N (cycle N+1).
//   - zero = ~|in_result, neg = in_result[WIDTH-1], computed at push; never recomputed.
//   - cnt update: push&~pop +1; pop&~push -1; push&pop unchanged (cnt=1: new entry becomes head next cycle).
//   - cnt=2: in_ready=0, in_valid ignored; pop same cycle frees slot, in_ready=1 the following cycle.
//   - cnt=0: out_ready ignored, no pop, out_count unchanged.
//   - Stall: while out_valid & ~out_ready, out_result/out_op/out_zero/out_neg held stable.
//   - FIFO order strictly preserved; pointers wrap 1->0.
//   - out_count += 1 on every pop; wraps 2^CNTW-1 -> 0 silently.
//   - Reset (any cycle, incl. mid-transfer): cnt=0, pointers=0, out_valid=0, in_ready=1 after edge,
//     out_result=0, out_op=0, out_zero=0, out_neg=0, out_count=0; buffered entries discarded.
//   - out_zero/out_neg read 0 whenever out_valid=0.
// TESTING
//   1 reset held 2 cycles -> out_valid=0, in_ready=1, out_count=0, all out_* = 0.
//   2 push 0x0000_0000 op=3, out_ready=1 -> next cycle out_valid=1, out_zero=1, out_neg=0, out_op=3; out_count=1 after pop.
//   3 out_ready=0, push 0x8000_0001 then 0x1234_5678 -> in_ready=0 after 2nd push, 3rd in_valid ignored; release
//     -> outputs 0x8000_0001 (neg=1) then 0x1234_5678 in order, out_count +2.
//   4 cnt=1, simultaneous push 0xFFFF_FFFF & pop -> cnt stays 1, next head 0xFFFF_FFFF, neg=1, zero=0.
//   5 cnt=2, assert reset for one cycle mid-stall -> out_valid=0, in_ready=1, out_count=0; no stale data emerges.
//   6 CNTW=4 override, 17 back-to-back transfers with out_ready=1 -> throughput 1/cycle, out_count wraps to 1.

Source files
------------

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer behind the ALU: captures {result, op, zero, neg}, latency 1 cycle push-to-visible.
// Backpressure: in_ready depends only on registered occupancy; out_* depend only on registered state.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [OPW-1:0]   out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNTW-1:0]  out_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [OPW-1:0]   op;
    logic             zero;
    logic             neg;
  } entry_t;

  entry_t          mem [2];
  entry_t          head_entry;
  logic [1:0]      cnt;
  logic            head;
  logic            tail;
  logic            push;
  logic            pop;
  logic [CNTW-1:0] count;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_count = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      cnt    <= 2'd0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        // Flags are derived once at capture and travel with the entry.
        mem[tail] <= '{result: in_result, op: in_op, zero: ~|in_result, neg: in_result[WIDTH-1]};
        tail      <= ~tail;
      end
      if (pop) begin
        head  <= ~head;
        count <= count + 1'b1;
      end
      if (push && !pop)
        cnt <= cnt + 2'd1;
      else if (pop && !push)
        cnt <= cnt - 2'd1;
    end
  end

  always_comb begin
    head_entry = mem[head];
    out_result = '0;
    out_op     = '0;
    out_zero   = 1'b0;
    out_neg    = 1'b0;
    // Everything reads zero while empty so no stale entry is ever visible.
    if (out_valid) begin
      out_result = head_entry.result;
      out_op     = head_entry.op;
      out_zero   = head_entry.zero;
      out_neg    = head_entry.neg;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vector table, back-to-back wrap run and random traffic vs a queue model.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_op;
  logic        out_zero;
  logic        out_neg;
  logic [15:0] out_count;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_result4;
  logic [2:0]  out_op4;
  logic        out_zero4;
  logic        out_neg4;
  logic [3:0]  out_count4;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op), .out_zero(out_zero), .out_neg(out_neg),
    .out_count(out_count)
  );

  alu_result_stage #(.CNTW(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_result(in_result), .in_op(in_op), .out_valid(out_valid4), .out_ready(out_ready),
    .out_result(out_result4), .out_op(out_op4), .out_zero(out_zero4), .out_neg(out_neg4),
    .out_count(out_count4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] result;
    logic [2:0]  op;
  } item_t;

  item_t       model_q[$];
  int unsigned model_count = 0;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] dat;
    logic [2:0]  op;
    logic        rdy;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_result;
    logic [2:0]  e_op;
    logic        e_zero;
    logic        e_neg;
    logic [15:0] e_count;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a plain queue of accepted items plus a delivery count.
  task automatic model_edge(input logic rst, input logic vld, input logic [31:0] dat,
                            input logic [2:0] op, input logic rdy);
    bit do_push, do_pop;
    item_t it;
    if (rst) begin
      model_q.delete();
      model_count = 0;
    end else begin
      do_push = vld && (model_q.size() < 2);
      do_pop  = rdy && (model_q.size() > 0);
      if (do_pop) begin
        void'(model_q.pop_front());
        model_count++;
      end
      if (do_push) begin
        it.result = dat;
        it.op     = op;
        model_q.push_back(it);
      end
    end
  endtask

  task automatic check_model();
    logic [31:0] r;
    logic [2:0]  o;
    r = 32'h0;
    o = 3'h0;
    if (model_q.size() > 0) begin
      r = model_q[0].result;
      o = model_q[0].op;
    end
    chk("m_valid", out_valid, model_q.size() > 0);
    chk("m_ready", in_ready, model_q.size() < 2);
    chk("m_result", out_result, r);
    chk("m_op", out_op, o);
    chk("m_zero", out_zero, (model_q.size() > 0) && (r == 32'h0));
    chk("m_neg", out_neg, (model_q.size() > 0) && r[31]);
    chk("m_count", out_count, model_count % 65536);
    chk("m_count4", out_count4, model_count % 16);
    chk("m_valid4", out_valid4, model_q.size() > 0);
  endtask

  task automatic cycle(input logic rst, input logic vld, input logic [31:0] dat,
                       input logic [2:0] op, input logic rdy);
    reset     = rst;
    in_valid  = vld;
    in_result = dat;
    in_op     = op;
    out_ready = rdy;
    @(posedge clk);
    model_edge(rst, vld, dat, op, rdy);
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_op = '0; out_ready = 1'b0;

    //            rst  vld  dat           op    rdy   valid ready result        op    z     n     count
    tbl[0]  = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'h0,        3'd3, 1'b1, 1'b1, 1'b1, 32'h0,        3'd3, 1'b1, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 16'd1};
    tbl[4]  = '{1'b0, 1'b1, 32'h8000_0001, 3'd1, 1'b0, 1'b1, 1'b1, 32'h8000_0001, 3'd1, 1'b0, 1'b1, 16'd1};
    tbl[5]  = '{1'b0, 1'b1, 32'h1234_5678, 3'd2, 1'b0, 1'b1, 1'b0, 32'h8000_0001, 3'd1, 1'b0, 1'b1, 16'd1};
    tbl[6]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 3'd7, 1'b0, 1'b1, 1'b0, 32'h8000_0001, 3'd1, 1'b0, 1'b1, 16'd1};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 3'd2, 1'b0, 1'b0, 16'd2};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 16'd3};
    tbl[9]  = '{1'b0, 1'b1, 32'h1111_1111, 3'd4, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 3'd4, 1'b0, 1'b0, 16'd3};
    tbl[10] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 3'd5, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 3'd5, 1'b0, 1'b1, 16'd4};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0005, 3'd6, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 3'd5, 1'b0, 1'b1, 16'd4};
    tbl[12] = '{1'b1, 1'b1, 32'hAAAA_AAAA, 3'd1, 1'b1, 1'b0, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 16'd0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 16'd0};

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].rst, tbl[i].vld, tbl[i].dat, tbl[i].op, tbl[i].rdy);
      chk($sformatf("v%0d_valid", i), out_valid, tbl[i].e_valid);
      chk($sformatf("v%0d_ready", i), in_ready, tbl[i].e_ready);
      chk($sformatf("v%0d_result", i), out_result, tbl[i].e_result);
      chk($sformatf("v%0d_op", i), out_op, tbl[i].e_op);
      chk($sformatf("v%0d_zero", i), out_zero, tbl[i].e_zero);
      chk($sformatf("v%0d_neg", i), out_neg, tbl[i].e_neg);
      chk($sformatf("v%0d_count", i), out_count, tbl[i].e_count);
    end

    // 17 back-to-back transfers: one item visible and one delivered every cycle.
    cycle(1'b1, 1'b0, 32'h0, 3'd0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 1'b1, 32'h100 + i, 3'(i), 1'b1);
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_result", out_result, 32'h100 + i);
      chk("b2b_count", out_count, 16'(i));
    end
    cycle(1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
    chk("b2b_count16", out_count, 16'd17);
    chk("b2b_wrap4", out_count4, 4'd1);
    chk("b2b_empty", out_valid, 1'b0);

    // Random traffic with occasional resets, zero results and negative results.
    for (int i = 0; i < 3000; i++) begin
      d = $urandom;
      case ($urandom_range(0, 7))
        0: d = 32'h0;
        1: d = d | 32'h8000_0000;
        default: ;
      endcase
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, d,
            3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
